// File: rtl/sobel_pkg.sv
// sobel_pkg
//   Shared definitions for the Sobel raster-scan sequencer:
//   - one-hot scan state encoding (4 bits)
//   - default image geometry
//   - clog2-derived counter/address widths for that default geometry
package sobel_pkg;

  localparam int IMG_W_DEF  = 64;
  localparam int IMG_H_DEF  = 64;
  localparam int COL_W_DEF  = $clog2(IMG_W_DEF);
  localparam int ROW_W_DEF  = $clog2(IMG_H_DEF);
  localparam int ADDR_W_DEF = $clog2(IMG_W_DEF * IMG_H_DEF);

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_RUN   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_e;

endpackage

// File: rtl/sobel_delay.sv
// sobel_delay
//   Fixed-depth shift register with a synchronous flush. Used to align the
//   {valid, address} result-write pair with the datapath latency.
// Ports:
//   clk    in   1      clock
//   flush  in   1      clears every stage on the next rising edge
//   din    in   WIDTH  stage-0 input
//   dout   out  WIDTH  output of the last stage (DEPTH cycles after din)
module sobel_delay #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (flush) q_reg <= '0;
          else       q_reg <= din;
        end
      end else begin : g_next
        always_ff @(posedge clk) begin
          if (flush) q_reg <= '0;
          else       q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/sobel_scan_ctrl.sv
// sobel_scan_ctrl
//   Raster-scan sequencer for the Sobel datapath. Issues frame-memory reads
//   in raster order, tags returning pixels, flags complete 3x3 windows and
//   emits result-write addresses (window centre) after the datapath latency.
//   Reports completion with sobel_done until start is released.
// Ports:
//   clk         in   1       clock
//   rst         in   1       synchronous reset, active low
//   start       in   1       level run request
//   stall       in   1       read port busy, holds the scan in RUN
//   rd_en       out  1       frame-memory read strobe
//   rd_addr     out  ADDR_W  read address (0 when rd_en is low)
//   line_shift  out  1       read data valid, shift into line buffers
//   win_vld     out  1       3x3 window complete this cycle
//   wr_en       out  1       result write strobe
//   wr_addr     out  ADDR_W  result address (0 when wr_en is low)
//   busy        out  1       RUN or DRAIN
//   sobel_done  out  1       DONE
module sobel_scan_ctrl
  import sobel_pkg::*;
#(
  parameter int IMG_W     = IMG_W_DEF,
  parameter int IMG_H     = IMG_H_DEF,
  parameter int SOBEL_LAT = 2,
  parameter int ADDR_W    = $clog2(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stall,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              line_shift,
  output logic              win_vld,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              sobel_done
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam int DRN_W = $clog2(SOBEL_LAT + 2);

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST   = ROW_W'(IMG_H - 1);
  localparam logic [DRN_W-1:0]  DRAIN_LAST = DRN_W'(SOBEL_LAT);
  localparam logic [ADDR_W-1:0] CENTRE_OFS = ADDR_W'(IMG_W + 1);

  state_e state_reg, state_next;

  logic [COL_W-1:0]  col_reg;
  logic [ROW_W-1:0]  row_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DRN_W-1:0]  drain_cnt_reg;

  logic [COL_W-1:0]  tag_col_reg;
  logic [ROW_W-1:0]  tag_row_reg;
  logic [ADDR_W-1:0] tag_addr_reg;
  logic              shift_reg;

  logic clear_cnt;
  logic advance;
  logic abort;
  logic last_pix;
  logic flush;

  logic [ADDR_W-1:0] centre_addr;
  logic [ADDR_W-1:0] wr_addr_in;
  logic [ADDR_W:0]   delay_in;
  logic [ADDR_W:0]   delay_out;

  assign last_pix = (row_reg == ROW_LAST) && (col_reg == COL_LAST);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // ---------------- next state and strobes ----------------
  always_comb begin
    state_next = state_reg;
    rd_en      = 1'b0;
    busy       = 1'b0;
    sobel_done = 1'b0;
    clear_cnt  = 1'b0;
    advance    = 1'b0;
    abort      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          clear_cnt  = 1'b1;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        rd_en   = !stall;
        advance = !stall;
        if (!start) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (advance && last_pix) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!start) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (drain_cnt_reg == DRAIN_LAST) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        sobel_done = 1'b1;
        if (!start) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_addr = rd_en ? addr_reg : '0;

  // ---------------- scan counters ----------------
  // addr_reg tracks row*IMG_W+col incrementally, so no multiplier is needed.
  always_ff @(posedge clk) begin
    if (!rst || clear_cnt) begin
      col_reg  <= '0;
      row_reg  <= '0;
      addr_reg <= '0;
    end else if (advance) begin
      addr_reg <= addr_reg + ADDR_W'(1);
      if (col_reg == COL_LAST) begin
        col_reg <= '0;
        row_reg <= row_reg + ROW_W'(1);
      end else begin
        col_reg <= col_reg + COL_W'(1);
      end
    end
  end

  // Counts DRAIN cycles; held at zero in every other state so each DRAIN
  // lasts exactly SOBEL_LAT+1 cycles.
  always_ff @(posedge clk) begin
    if (!rst || state_reg != ST_DRAIN) drain_cnt_reg <= '0;
    else                               drain_cnt_reg <= drain_cnt_reg + DRN_W'(1);
  end

  // ---------------- returned-pixel tag ----------------
  assign flush = !rst || abort;

  always_ff @(posedge clk) begin
    if (flush) shift_reg <= 1'b0;
    else       shift_reg <= rd_en;
  end

  // Tags only move with a read; an abort leaves them untouched.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_col_reg  <= '0;
      tag_row_reg  <= '0;
      tag_addr_reg <= '0;
    end else if (rd_en) begin
      tag_col_reg  <= col_reg;
      tag_row_reg  <= row_reg;
      tag_addr_reg <= addr_reg;
    end
  end

  assign line_shift = shift_reg;
  assign win_vld    = shift_reg && (tag_row_reg >= ROW_W'(2)) && (tag_col_reg >= COL_W'(2));

  // Window centre is one row up and one column left of the newest pixel;
  // win_vld guarantees tag_addr_reg >= 2*IMG_W+2, so no underflow.
  assign centre_addr = tag_addr_reg - CENTRE_OFS;
  assign wr_addr_in  = win_vld ? centre_addr : {ADDR_W{1'b0}};
  assign delay_in    = {win_vld, wr_addr_in};

  sobel_delay #(
    .DEPTH (SOBEL_LAT),
    .WIDTH (ADDR_W + 1)
  ) u_wr_delay (
    .clk   (clk),
    .flush (flush),
    .din   (delay_in),
    .dout  (delay_out)
  );

  assign wr_en   = delay_out[ADDR_W];
  assign wr_addr = delay_out[ADDR_W-1:0];

endmodule

// File: tb/tb_sobel_scan_ctrl.sv
module tb_sobel_scan_ctrl;

  localparam int NI  = 2;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stall;

  logic       rd_en_o      [NI];
  logic [3:0] rd_addr_o    [NI];
  logic       line_shift_o [NI];
  logic       win_vld_o    [NI];
  logic       wr_en_o      [NI];
  logic [3:0] wr_addr_o    [NI];
  logic       busy_o       [NI];
  logic       done_o       [NI];

  always #5 clk = ~clk;

  // instance 0: 4x4 image, instance 1: 5x3 image, shared stimulus
  sobel_scan_ctrl #(.IMG_W(4), .IMG_H(4), .SOBEL_LAT(LAT)) u_dut0 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rd_en(rd_en_o[0]), .rd_addr(rd_addr_o[0]), .line_shift(line_shift_o[0]),
    .win_vld(win_vld_o[0]), .wr_en(wr_en_o[0]), .wr_addr(wr_addr_o[0]),
    .busy(busy_o[0]), .sobel_done(done_o[0])
  );

  sobel_scan_ctrl #(.IMG_W(5), .IMG_H(3), .SOBEL_LAT(LAT)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
    .rd_en(rd_en_o[1]), .rd_addr(rd_addr_o[1]), .line_shift(line_shift_o[1]),
    .win_vld(win_vld_o[1]), .wr_en(wr_en_o[1]), .wr_addr(wr_addr_o[1]),
    .busy(busy_o[1]), .sobel_done(done_o[1])
  );

  function automatic int img_w(int i);
    return (i == 0) ? 4 : 5;
  endfunction

  function automatic int img_h(int i);
    return (i == 0) ? 4 : 3;
  endfunction

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc = cyc + 1;

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 scanning, 2 draining, 3 done
  int m_mode [NI];
  int m_k    [NI];   // reads issued in the current frame
  int m_dcnt [NI];   // drain cycles elapsed
  bit m_ls   [NI];   // a pixel returns this cycle
  int m_ls_k [NI];   // raster index of that pixel
  int wq_due [NI][$];
  int wq_addr[NI][$];

  int  mw, mh;
  bit  e_rd, e_win, e_wr;

  initial begin
    for (int i = 0; i < NI; i++) begin
      m_mode[i] = 0; m_k[i] = 0; m_dcnt[i] = 0; m_ls[i] = 1'b0; m_ls_k[i] = 0;
    end
  end

  // ---------------- event logs (relative to frame start) ----------------
  bit log_on = 1'b0;
  int t0 = 0;
  int rd_addr_log[$], rd_cyc_log[$], win_log[$], wr_cyc_log[$], wr_addr_log[$];
  int wr1_addr_log[$];
  int rd1_cnt;
  int done_rise, done_fall, done1_rise;

  task automatic clear_logs();
    rd_addr_log.delete(); rd_cyc_log.delete(); win_log.delete();
    wr_cyc_log.delete(); wr_addr_log.delete(); wr1_addr_log.delete();
    rd1_cnt = 0; done_rise = -1; done_fall = -1; done1_rise = -1;
  endtask

  // ---------------- compare + model advance, mid-cycle ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        mw    = img_w(i);
        e_rd  = (m_mode[i] == 1) && !stall;
        e_win = m_ls[i] && (m_ls_k[i] / mw >= 2) && (m_ls_k[i] % mw >= 2);
        e_wr  = (wq_due[i].size() > 0) && (wq_due[i][0] == cyc);
        chk($sformatf("rd_en[%0d]", i), int'(rd_en_o[i]), int'(e_rd));
        if (e_rd) chk($sformatf("rd_addr[%0d]", i), int'(rd_addr_o[i]), m_k[i]);
        chk($sformatf("line_shift[%0d]", i), int'(line_shift_o[i]), int'(m_ls[i]));
        chk($sformatf("win_vld[%0d]", i), int'(win_vld_o[i]), int'(e_win));
        chk($sformatf("wr_en[%0d]", i), int'(wr_en_o[i]), int'(e_wr));
        if (e_wr) chk($sformatf("wr_addr[%0d]", i), int'(wr_addr_o[i]), wq_addr[i][0]);
        chk($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(m_mode[i] == 1 || m_mode[i] == 2));
        chk($sformatf("sobel_done[%0d]", i), int'(done_o[i]), int'(m_mode[i] == 3));
        if (m_mode[i] == 0) begin
          chk($sformatf("idle_rd_addr[%0d]", i), int'(rd_addr_o[i]), 0);
          chk($sformatf("idle_wr_addr[%0d]", i), int'(wr_addr_o[i]), 0);
        end
      end
    end

    if (log_on) begin
      if (rd_en_o[0]) begin rd_addr_log.push_back(int'(rd_addr_o[0])); rd_cyc_log.push_back(cyc - t0); end
      if (win_vld_o[0]) win_log.push_back(cyc - t0);
      if (wr_en_o[0]) begin wr_cyc_log.push_back(cyc - t0); wr_addr_log.push_back(int'(wr_addr_o[0])); end
      if (done_o[0] && done_rise < 0) done_rise = cyc - t0;
      if (!done_o[0] && done_rise >= 0 && done_fall < 0) done_fall = cyc - t0;
      if (rd_en_o[1]) rd1_cnt++;
      if (wr_en_o[1]) wr1_addr_log.push_back(int'(wr_addr_o[1]));
      if (done_o[1] && done1_rise < 0) done1_rise = cyc - t0;
    end
    for (int i = 0; i < NI; i++)
      if (wr_en_o[i]) $display("inst %0d write cycle %0d addr %0d", i, cyc, wr_addr_o[i]);

    // advance the model to the next cycle using the inputs sampled at the edge
    for (int i = 0; i < NI; i++) begin
      mw   = img_w(i);
      mh   = img_h(i);
      e_rd = (m_mode[i] == 1) && !stall;
      if (!rst) begin
        m_mode[i] = 0; m_ls[i] = 1'b0;
        wq_due[i].delete(); wq_addr[i].delete();
      end else begin
        if (wq_due[i].size() > 0 && wq_due[i][0] == cyc) begin
          void'(wq_due[i].pop_front()); void'(wq_addr[i].pop_front());
        end
        m_ls[i] = e_rd;
        if (e_rd) begin
          m_ls_k[i] = m_k[i];
          if (m_k[i] / mw >= 2 && m_k[i] % mw >= 2) begin
            wq_due[i].push_back(cyc + 1 + LAT);
            wq_addr[i].push_back(m_k[i] - mw - 1);
          end
        end
        case (m_mode[i])
          0: if (start) begin m_mode[i] = 1; m_k[i] = 0; end
          1, 2: begin
            if (!start) begin
              m_mode[i] = 0; m_ls[i] = 1'b0;
              wq_due[i].delete(); wq_addr[i].delete();
            end else if (m_mode[i] == 1) begin
              if (e_rd) begin
                m_k[i]++;
                if (m_k[i] == mw * mh) begin m_mode[i] = 2; m_dcnt[i] = 0; end
              end
            end else begin
              m_dcnt[i]++;
              if (m_dcnt[i] == LAT + 1) m_mode[i] = 3;
            end
          end
          default: if (!start) m_mode[i] = 0;
        endcase
      end
    end
    if (!rst) chk_on = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic begin_frame();
    clear_logs();
    log_on = 1'b1;
    t0     = cyc;
    start  = 1'b1;
  endtask

  task automatic wait_done0(input int max_cyc);
    int n;
    n = 0;
    while (!done_o[0] && n < max_cyc) begin
      step(1);
      n++;
    end
    chk("done_wait_timeout", int'(n >= max_cyc), 0);
  endtask

  int exp_win[4]    = '{12, 13, 16, 17};
  int exp_wr_cyc[4] = '{14, 15, 18, 19};
  int exp_wr_adr[4] = '{5, 6, 9, 10};
  int exp_wr1[3]    = '{6, 7, 8};

  task automatic run_nominal(input string tag);
    begin_frame();
    wait_done0(100);
    while (cyc - t0 < 25) step(1);
    start = 1'b0;
    step(3);
    log_on = 1'b0;
    chk({tag, "_rd_count"}, rd_addr_log.size(), 16);
    for (int i = 0; i < rd_addr_log.size() && i < 16; i++) begin
      chk({tag, "_rd_addr"}, rd_addr_log[i], i);
      chk({tag, "_rd_cycle"}, rd_cyc_log[i], i + 1);
    end
    chk({tag, "_win_count"}, win_log.size(), 4);
    for (int i = 0; i < win_log.size() && i < 4; i++)
      chk({tag, "_win_cycle"}, win_log[i], exp_win[i]);
    chk({tag, "_wr_count"}, wr_cyc_log.size(), 4);
    for (int i = 0; i < wr_cyc_log.size() && i < 4; i++) begin
      chk({tag, "_wr_cycle"}, wr_cyc_log[i], exp_wr_cyc[i]);
      chk({tag, "_wr_addr"}, wr_addr_log[i], exp_wr_adr[i]);
    end
    chk({tag, "_done_rise"}, done_rise, 20);
    chk({tag, "_done_fall"}, done_fall, 26);
    chk({tag, "_ns_rd_count"}, rd1_cnt, 15);
    chk({tag, "_ns_wr_count"}, wr1_addr_log.size(), 3);
    for (int i = 0; i < wr1_addr_log.size() && i < 3; i++)
      chk({tag, "_ns_wr_addr"}, wr1_addr_log[i], exp_wr1[i]);
    chk({tag, "_ns_done_rise"}, done1_rise, 19);
  endtask

  int late_wr;
  int r_cyc;
  int n_wait;

  initial begin
    rst = 1'b0; start = 1'b0; stall = 1'b0;
    step(2);
    rst = 1'b1;
    step(3);

    // nominal frame
    run_nominal("nominal");

    // stall on cycles 3..5
    begin_frame();
    step(3); stall = 1'b1;
    step(3); stall = 1'b0;
    wait_done0(100);
    step(1);
    start = 1'b0;
    step(3);
    log_on = 1'b0;
    chk("stall_rd_count", rd_addr_log.size(), 16);
    for (int i = 0; i < rd_addr_log.size() && i < 16; i++) begin
      chk("stall_rd_addr", rd_addr_log[i], i);
      chk("stall_rd_cycle", rd_cyc_log[i], (i < 2) ? i + 1 : i + 4);
    end
    chk("stall_done_rise", done_rise, 23);

    // abort at cycle 13
    begin_frame();
    step(13);
    start = 1'b0;
    step(1);
    chk("abort_busy", int'(busy_o[0]), 0);
    step(5);
    log_on = 1'b0;
    late_wr = 0;
    foreach (wr_cyc_log[i]) if (wr_cyc_log[i] > 13) late_wr++;
    chk("abort_late_wr", late_wr, 0);
    chk("abort_done_rise", done_rise, -1);

    // reset in the middle of DRAIN with start held
    begin_frame();
    step(18);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("rst_rd_en", int'(rd_en_o[0]), 0);
    chk("rst_rd_addr", int'(rd_addr_o[0]), 0);
    chk("rst_line_shift", int'(line_shift_o[0]), 0);
    chk("rst_win_vld", int'(win_vld_o[0]), 0);
    chk("rst_wr_en", int'(wr_en_o[0]), 0);
    chk("rst_wr_addr", int'(wr_addr_o[0]), 0);
    chk("rst_busy", int'(busy_o[0]), 0);
    chk("rst_done", int'(done_o[0]), 0);
    step(1);
    chk("rst_restart_rd_en", int'(rd_en_o[0]), 1);
    chk("rst_restart_rd_addr", int'(rd_addr_o[0]), 0);
    wait_done0(100);
    step(1);
    start = 1'b0;
    step(3);
    log_on = 1'b0;
    chk("rst_done_rise", done_rise, 39);

    // done handshake: a fresh start replays the nominal sequence
    run_nominal("replay");

    // randomized frames: random stalls, occasional abort or reset
    for (int f = 0; f < 30; f++) begin
      start = 1'b1;
      r_cyc = $urandom_range(2, 30);
      n_wait = 0;
      while (!done_o[0] && n_wait < 300) begin
        stall = ($urandom_range(0, 3) == 0);
        if (f % 7 == 3 && n_wait == r_cyc) break;
        if (f % 5 == 2 && n_wait == r_cyc) rst = 1'b0;
        else                               rst = 1'b1;
        step(1);
        n_wait++;
      end
      rst = 1'b1;
      chk("random_frame_timeout", int'(n_wait >= 300), 0);
      step($urandom_range(0, 3));
      start = 1'b0;
      stall = 1'b0;
      step(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
